// File: rtl/bus_arbiter.sv
// N:1 packet arbiter (external select or round-robin) broadcasting the granted source through one output register.
// Latency 1 cycle per accepted beat; ready_in follows the output register's free slot, so backpressure is ready_out alone.
module bus_arbiter #(
   parameter int NUM_INPUT  = 8,
   parameter int NUM_OUTPUT = 8,
   parameter int SEL_BIT    = 3,
   parameter int DATA_WIDTH = 8,
   parameter int MODE       = 1,
   parameter int TIMEOUT    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_INPUT-1:0]             valid_in,
   input  logic [NUM_INPUT-1:0]             last_in,
   input  logic [NUM_INPUT*DATA_WIDTH-1:0]  data_in,
   input  logic [SEL_BIT-1:0]               sel_in,
   output logic [NUM_INPUT-1:0]             ready_in,
   output logic [NUM_OUTPUT*DATA_WIDTH-1:0] data_out,
   output logic                             valid_out,
   output logic                             last_out,
   input  logic                             ready_out,
   output logic [SEL_BIT-1:0]               grant_out,
   output logic                             busy_out
);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [SEL_BIT-1:0]      grant_q, grant_d;
   logic [SEL_BIT-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic                    out_vld_q, out_vld_d;
   logic                    out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0]   out_dat_q, out_dat_d;

   logic                    g_vld;
   logic                    g_last;
   logic [DATA_WIDTH-1:0]   g_dat;
   logic                    arb_hit;
   logic [SEL_BIT-1:0]      arb_idx;
   logic [SEL_BIT-1:0]      grant_nxt;
   logic                    out_free;
   logic                    xfer;

   // Source currently holding the grant.
   always_comb begin
      g_vld  = 1'b0;
      g_last = 1'b0;
      g_dat  = '0;
      for (int i = 0; i < NUM_INPUT; i++) begin
         if (int'(grant_q) == i) begin
            g_vld  = valid_in[i];
            g_last = last_in[i];
            g_dat  = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Arbitration candidate; out-of-range sel_in never matches any source.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      if (MODE == 0) begin
         for (int i = 0; i < NUM_INPUT; i++) begin
            if (int'(sel_in) == i && valid_in[i]) begin
               arb_hit = 1'b1;
               arb_idx = SEL_BIT'(i);
            end
         end
      end else begin
         for (int k = 0; k < NUM_INPUT; k++) begin
            for (int i = 0; i < NUM_INPUT; i++) begin
               if (!arb_hit && ((int'(rr_ptr_q) + k) % NUM_INPUT) == i && valid_in[i]) begin
                  arb_hit = 1'b1;
                  arb_idx = SEL_BIT'(i);
               end
            end
         end
      end
   end

   assign grant_nxt = (int'(grant_q) >= NUM_INPUT - 1) ? '0 : grant_q + 1'b1;
   assign out_free  = ~out_vld_q | ready_out;
   assign xfer      = (state_q == GRANT) & g_vld & out_free;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      tmo_cnt_d = tmo_cnt_q;
      case (state_q)
         IDLE: begin
            tmo_cnt_d = '0;
            if (arb_hit) begin
               state_d = GRANT;
               grant_d = arb_idx;
            end
         end
         GRANT: begin
            if (xfer) begin
               tmo_cnt_d = '0;
               if (g_last) begin
                  state_d  = IDLE;
                  rr_ptr_d = grant_nxt;
               end
            end else if (!g_vld && TIMEOUT > 0) begin
               // Stalled-but-valid cycles do not count: only a silent source is evicted.
               if (int'(tmo_cnt_q) + 1 >= TIMEOUT) begin
                  state_d   = IDLE;
                  rr_ptr_d  = grant_nxt;
                  tmo_cnt_d = '0;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      out_dat_d  = out_dat_q;
      if (xfer) begin
         out_vld_d  = 1'b1;
         out_last_d = g_last;
         out_dat_d  = g_dat;
      end else if (ready_out) begin
         out_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         tmo_cnt_q  <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         out_dat_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         tmo_cnt_q  <= tmo_cnt_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         out_dat_q  <= out_dat_d;
      end
   end

   always_comb begin
      ready_in = '0;
      for (int i = 0; i < NUM_INPUT; i++) begin
         if (state_q == GRANT && int'(grant_q) == i) begin
            ready_in[i] = out_free;
         end
      end
   end

   for (genvar j = 0; j < NUM_OUTPUT; j++) begin : g_copy
      assign data_out[j*DATA_WIDTH +: DATA_WIDTH] = out_dat_q;
   end

   assign valid_out = out_vld_q;
   assign last_out  = out_last_q;
   assign grant_out = grant_q;
   assign busy_out  = (state_q == GRANT);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized packet stream checked against a round-robin packet-order model.
module tb_bus_arbiter;
   localparam int NI = 4;
   localparam int NO = 2;
   localparam int SB = 3;
   localparam int DW = 8;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NI-1:0]   valid_in, last_in;
   logic [NI*DW-1:0] data_in;
   logic [SB-1:0]   sel_in;
   logic            ready_out;
   logic [NI-1:0]   ready_in, m0_ready_in;
   logic [NO*DW-1:0] data_out, m0_data_out;
   logic            valid_out, last_out, m0_valid_out, m0_last_out;
   logic [SB-1:0]   grant_out, m0_grant_out;
   logic            busy_out, m0_busy_out;

   int checks = 0;
   int failures = 0;

   logic [8:0] src_mem [NI][32];
   int         src_rd [NI];
   int         src_n  [NI];
   int         stall  [NI];
   logic [8:0] exp_q [$];
   int         exp_src [$];

   always #5 clk = ~clk;

   bus_arbiter #(.NUM_INPUT(NI), .NUM_OUTPUT(NO), .SEL_BIT(SB), .DATA_WIDTH(DW), .MODE(1), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .last_in(last_in), .data_in(data_in), .sel_in(sel_in),
      .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out), .last_out(last_out),
      .ready_out(ready_out), .grant_out(grant_out), .busy_out(busy_out));

   bus_arbiter #(.NUM_INPUT(NI), .NUM_OUTPUT(NO), .SEL_BIT(SB), .DATA_WIDTH(DW), .MODE(0), .TIMEOUT(TO)) dut_m0 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .last_in(last_in), .data_in(data_in), .sel_in(sel_in),
      .ready_in(m0_ready_in), .data_out(m0_data_out), .valid_out(m0_valid_out), .last_out(m0_last_out),
      .ready_out(ready_out), .grant_out(m0_grant_out), .busy_out(m0_busy_out));

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; valid_in = '0; last_in = '0; data_in = '0; sel_in = '0; ready_out = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (valid_out !== 1'b0 || last_out !== 1'b0 || data_out !== 16'h0000 || grant_out !== 3'd0 ||
          busy_out !== 1'b0 || ready_in !== 4'b0000) begin
         failures++;
         $display("FAIL reset_state: got vld=%b last=%b dat=%h grant=%0d busy=%b rdy=%b, want all zero",
                  valid_out, last_out, data_out, grant_out, busy_out, ready_in);
      end
      @(negedge clk); #1;
      checks++;
      if (busy_out !== 1'b0 || m0_busy_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_no_req: got busy=%b m0_busy=%b, want 0 0", busy_out, m0_busy_out);
      end
   endtask

   task automatic test_rr_order();
      int exp_g[5];
      int ngr, pend_cyc, pend_g;
      logic prev_busy;
      exp_g = '{0, 1, 2, 3, 0};
      do_reset();
      valid_in = 4'hF; last_in = 4'hF; data_in = 32'h13121110; ready_out = 1'b1;
      ngr = 0; pend_cyc = -1; pend_g = 0; prev_busy = 1'b0;
      for (int cyc = 0; cyc < 11; cyc++) begin
         #1;
         if (cyc == pend_cyc) begin
            checks++;
            if (valid_out !== 1'b1 || last_out !== 1'b1 || data_out[7:0] !== 8'(8'h10 + pend_g) ||
                data_out[15:8] !== 8'(8'h10 + pend_g)) begin
               failures++;
               $display("FAIL rr_beat%0d: got vld=%b last=%b dat=%h, want vld=1 last=1 both copies %h",
                        ngr, valid_out, last_out, data_out, 8'(8'h10 + pend_g));
            end
         end
         if (busy_out && !prev_busy) begin
            checks++;
            if (ngr >= 5 || grant_out !== SB'(exp_g[ngr]) || cyc != 2 * ngr + 1) begin
               failures++;
               $display("FAIL rr_grant%0d: got grant=%0d at cycle %0d, want grant=%0d at cycle %0d",
                        ngr, grant_out, cyc, (ngr < 5) ? exp_g[ngr] : -1, 2 * ngr + 1);
            end
            if (ngr < 5) pend_g = exp_g[ngr];
            pend_cyc = cyc + 1;
            ngr++;
         end
         prev_busy = busy_out;
         @(negedge clk);
      end
      checks++;
      if (ngr != 5) begin
         failures++;
         $display("FAIL rr_grant_count: got %0d grants, want 5", ngr);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] bt[3];
      int idx, got, hold;
      bt[0] = 8'hA1; bt[1] = 8'hA2; bt[2] = 8'hA3;
      do_reset();
      idx = 0; got = 0; hold = 0;
      for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
         if (idx < 3) begin
            valid_in = 4'b0100; data_in = {8'h00, bt[idx], 16'h0000}; last_in = (idx == 2) ? 4'b0100 : 4'b0000;
         end else begin
            valid_in = '0; last_in = '0;
         end
         if (valid_out && data_out[7:0] == 8'hA2 && hold < 3) begin
            ready_out = 1'b0; hold++;
         end else begin
            ready_out = 1'b1;
         end
         #1;
         if (!ready_out) begin
            checks++;
            if (valid_out !== 1'b1 || data_out !== {2{8'hA2}} || ready_in !== 4'b0000) begin
               failures++;
               $display("FAIL bp_hold: got vld=%b dat=%h rdy=%b, want vld=1 dat=a2a2 rdy=0000", valid_out, data_out, ready_in);
            end
         end
         if (valid_out && ready_out) begin
            checks++;
            if (got >= 3 || data_out[7:0] !== bt[got] || data_out[15:8] !== bt[got] || last_out !== (got == 2)) begin
               failures++;
               $display("FAIL bp_beat%0d: got dat=%h last=%b, want both copies %h last=%b",
                        got, data_out, last_out, (got < 3) ? bt[got] : 8'h00, got == 2);
            end
            got++;
         end
         if (valid_in[2] && ready_in[2]) idx++;
         @(negedge clk);
      end
      checks++;
      if (got != 3 || hold != 3 || idx != 3) begin
         failures++;
         $display("FAIL bp_count: got beats=%0d stalls=%0d sent=%0d, want 3 3 3", got, hold, idx);
      end
      #1;
      checks++;
      if (valid_out !== 1'b0) begin
         failures++;
         $display("FAIL bp_no_dup: got vld=%b dat=%h after last beat, want vld=0", valid_out, data_out);
      end
   endtask

   task automatic test_timeout();
      logic sent55, sent77;
      int xfer_cyc, n55, n77, nother, idle_cyc, busy_after, g2_cyc;
      do_reset();
      data_in = {8'h00, 8'h77, 8'h55, 8'h00}; last_in = 4'b0100; ready_out = 1'b1;
      sent55 = 1'b0; sent77 = 1'b0; xfer_cyc = -10; n55 = 0; n77 = 0; nother = 0;
      idle_cyc = -1; busy_after = 0; g2_cyc = -1;
      for (int cyc = 0; cyc < 30 && !(g2_cyc >= 0 && n77 == 1); cyc++) begin
         valid_in = {1'b0, !sent77, !sent55, 1'b0};
         #1;
         if (valid_out && ready_out) begin
            if (data_out[7:0] == 8'h55) n55++;
            else if (data_out[7:0] == 8'h77) n77++;
            else nother++;
         end
         if (sent55 && idle_cyc < 0) begin
            if (busy_out) busy_after++;
            else idle_cyc = cyc;
         end
         if (g2_cyc < 0 && busy_out && grant_out == 3'd2) g2_cyc = cyc;
         if (valid_in[1] && ready_in[1]) begin sent55 = 1'b1; xfer_cyc = cyc; end
         if (valid_in[2] && ready_in[2]) sent77 = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (xfer_cyc != 1) begin
         failures++;
         $display("FAIL to_first_grant: got 0x55 transfer at cycle %0d, want 1", xfer_cyc);
      end
      checks++;
      if (busy_after != TO || idle_cyc != xfer_cyc + TO + 1) begin
         failures++;
         $display("FAIL to_release: got %0d idle grant cycles, idle at %0d, want %0d and %0d",
                  busy_after, idle_cyc, TO, xfer_cyc + TO + 1);
      end
      checks++;
      if (g2_cyc != idle_cyc + 1) begin
         failures++;
         $display("FAIL to_next_grant: got source 2 granted at cycle %0d, want %0d", g2_cyc, idle_cyc + 1);
      end
      checks++;
      if (n55 != 1 || n77 != 1 || nother != 0) begin
         failures++;
         $display("FAIL to_beats: got 55x%0d 77x%0d other=%0d, want 1 1 0", n55, n77, nother);
      end
      valid_in = '0;
   endtask

   task automatic test_mode0();
      logic [SB-1:0] bad_sel[3];
      bad_sel[0] = 3'd5; bad_sel[1] = 3'd4; bad_sel[2] = 3'd7;
      do_reset();
      sel_in = 3'd3; valid_in = 4'b1000; last_in = 4'b1000; data_in = {8'h3C, 24'h000000}; ready_out = 1'b1;
      #1;
      checks++;
      if (m0_busy_out !== 1'b0 || m0_ready_in !== 4'b0000) begin
         failures++;
         $display("FAIL m0_arb_cycle: got busy=%b rdy=%b, want 0 0000", m0_busy_out, m0_ready_in);
      end
      @(negedge clk); #1;
      checks++;
      if (m0_busy_out !== 1'b1 || m0_grant_out !== 3'd3 || m0_ready_in !== 4'b1000) begin
         failures++;
         $display("FAIL m0_grant3: got busy=%b grant=%0d rdy=%b, want 1 3 1000", m0_busy_out, m0_grant_out, m0_ready_in);
      end
      @(negedge clk);
      valid_in = '0; last_in = '0;
      #1;
      checks++;
      if (m0_busy_out !== 1'b0 || m0_valid_out !== 1'b1 || m0_last_out !== 1'b1 || m0_data_out !== {2{8'h3C}}) begin
         failures++;
         $display("FAIL m0_beat: got busy=%b vld=%b last=%b dat=%h, want 0 1 1 3c3c",
                  m0_busy_out, m0_valid_out, m0_last_out, m0_data_out);
      end
      valid_in = 4'hF;
      for (int s = 0; s < 3; s++) begin
         sel_in = bad_sel[s];
         for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checks++;
            if (m0_busy_out !== 1'b0 || m0_ready_in !== 4'b0000 || m0_valid_out !== 1'b0) begin
               failures++;
               $display("FAIL m0_bad_sel%0d: got busy=%b rdy=%b vld=%b, want 0 0000 0",
                        bad_sel[s], m0_busy_out, m0_ready_in, m0_valid_out);
            end
         end
      end
      sel_in = 3'd1;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (m0_busy_out !== 1'b1 || m0_grant_out !== 3'd1) begin
         failures++;
         $display("FAIL m0_grant1: got busy=%b grant=%0d, want 1 1", m0_busy_out, m0_grant_out);
      end
      valid_in = '0; sel_in = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready_out = 1'b1; valid_in = 4'b0010; last_in = 4'b0010; data_in = {8'h31, 8'h00, 8'h11, 8'h00};
      #1; @(negedge clk);
      #1;
      checks++;
      if (busy_out !== 1'b1 || grant_out !== 3'd1) begin
         failures++;
         $display("FAIL rm_grant1: got busy=%b grant=%0d, want 1 1", busy_out, grant_out);
      end
      @(negedge clk);
      valid_in = 4'b1000; last_in = 4'b0000;
      #1; @(negedge clk);
      #1;
      checks++;
      if (busy_out !== 1'b1 || grant_out !== 3'd3 || ready_in !== 4'b1000) begin
         failures++;
         $display("FAIL rm_grant3: got busy=%b grant=%0d rdy=%b, want 1 3 1000", busy_out, grant_out, ready_in);
      end
      @(negedge clk);
      rst = 1'b1; valid_in = 4'hF;
      #1; @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (valid_out !== 1'b0 || last_out !== 1'b0 || data_out !== 16'h0000 || ready_in !== 4'b0000 ||
          busy_out !== 1'b0 || grant_out !== 3'd0) begin
         failures++;
         $display("FAIL rm_after_rst: got vld=%b last=%b dat=%h rdy=%b busy=%b grant=%0d, want all zero",
                  valid_out, last_out, data_out, ready_in, busy_out, grant_out);
      end
      @(negedge clk); #1;
      checks++;
      if (busy_out !== 1'b1 || grant_out !== 3'd0 || valid_out !== 1'b0) begin
         failures++;
         $display("FAIL rm_first_grant: got busy=%b grant=%0d vld=%b, want 1 0 0", busy_out, grant_out, valid_out);
      end
      valid_in = '0;
   endtask

   task automatic test_random();
      logic [8:0]    b;
      logic [NI-1:0] exp_rdy;
      int            len, cyc, bad_rdy, bad_dat;
      do_reset();
      exp_q.delete(); exp_src.delete();
      bad_rdy = 0; bad_dat = 0;
      for (int s = 0; s < NI; s++) begin src_rd[s] = 0; src_n[s] = 0; stall[s] = 0; end
      // Every source always has a packet waiting, so the grant order is strict rotation.
      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < NI; s++) begin
            len = $urandom_range(1, 3);
            exp_src.push_back(s);
            for (int k = 0; k < len; k++) begin
               b = {(k == len - 1), 8'($urandom)};
               src_mem[s][src_n[s]] = b;
               src_n[s]++;
               exp_q.push_back(b);
            end
         end
      end
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 3000) begin
         for (int s = 0; s < NI; s++) begin
            if (src_rd[s] < src_n[s] && stall[s] == 0) begin
               valid_in[s] = 1'b1;
               data_in[s*DW +: DW] = src_mem[s][src_rd[s]][7:0];
               last_in[s] = src_mem[s][src_rd[s]][8];
            end else begin
               valid_in[s] = 1'b0;
               data_in[s*DW +: DW] = 8'($urandom);
               last_in[s] = 1'($urandom);
            end
         end
         ready_out = ($urandom_range(0, 3) != 0);
         #1;
         if (ready_in != '0) begin
            exp_rdy = (exp_src.size() > 0) ? 4'(4'b0001 << exp_src[0]) : 4'b0000;
            checks++;
            if (ready_in !== exp_rdy) begin
               failures++;
               bad_rdy++;
               if (bad_rdy < 5) $display("FAIL rnd_ready cyc%0d: got rdy=%b, want %b", cyc, ready_in, exp_rdy);
            end
         end
         if (valid_out && ready_out) begin
            b = exp_q.pop_front();
            checks++;
            if ({last_out, data_out[7:0]} !== b || data_out[15:8] !== b[7:0]) begin
               failures++;
               bad_dat++;
               if (bad_dat < 5) $display("FAIL rnd_beat cyc%0d: got last=%b dat=%h, want last=%b both copies %h",
                                         cyc, last_out, data_out, b[8], b[7:0]);
            end
         end
         for (int s = 0; s < NI; s++) begin
            if (valid_in[s] && ready_in[s]) begin
               b = src_mem[s][src_rd[s]];
               src_rd[s]++;
               if (b[8]) begin
                  if (exp_src.size() > 0 && exp_src[0] == s) void'(exp_src.pop_front());
                  stall[s] = 0;
               end else begin
                  stall[s] = $urandom_range(0, 2);
               end
            end else if (stall[s] > 0) begin
               stall[s]--;
            end
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rnd_drain: got %0d beats still expected after %0d cycles, want 0", exp_q.size(), cyc);
      end
      valid_in = '0; ready_out = 1'b1;
   endtask

   initial begin
      rst = 1'b1; valid_in = '0; last_in = '0; data_in = '0; sel_in = '0; ready_out = 1'b1;
      test_reset();
      test_rr_order();
      test_backpressure();
      test_timeout();
      test_mode0();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
